// File: rtl/alu_input_stage.sv
// Operand/opcode capture stage for the ALU: debounced "go" button latches the
// switch operands and offers them downstream over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for the synchronized button to go high
// PRESS   | counting consecutive high samples to qualify a press
// HOLD    | operands captured, out_valid high, waiting for out_ready
// RELEASE | counting consecutive low samples before accepting a new press
module alu_input_stage #(
  parameter int WIDTH     = 4,
  parameter int OP_LEN    = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic [WIDTH-1:0]  sw_a,
  input  logic [WIDTH-1:0]  sw_b,
  input  logic [OP_LEN-1:0] sw_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [OP_LEN-1:0] out_op,
  output logic              busy,
  output logic [7:0]        op_count
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] db_cnt;
  logic          btn_meta;
  logic          btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      busy      <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS;
            db_cnt <= CW'(1);
            busy   <= 1'b1;
          end else begin
            db_cnt <= '0;
          end
        end
        PRESS: begin
          if (!btn_s) begin
            state  <= IDLE;
            db_cnt <= '0;
            busy   <= 1'b0;
          end else if (db_cnt == CNT_LAST) begin
            out_a     <= sw_a;
            out_b     <= sw_b;
            out_op    <= sw_op;
            out_valid <= 1'b1;
            state     <= HOLD;
            db_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        HOLD: begin
          // The capture edge itself never sees HOLD, so a transfer is at least one edge later.
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= RELEASE;
            db_cnt    <= '0;
          end
        end
        RELEASE: begin
          if (btn_s) begin
            db_cnt <= '0;
          end else if (db_cnt == CNT_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
            busy   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
